// File: rtl/mm3x3_pkg.sv
// mm3x3_pkg: shared types and constants for the 3x3 matrix-multiplier stream controller.
//   state_e    controller FSM states
//   NUM_ELEMS  elements per 3x3 matrix
//   DEF_*_W    default operand/result widths
//   elem_lsb() LSB position of element idx on a flat bus of w-bit elements
package mm3x3_pkg;

    localparam int NUM_ELEMS  = 9;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_RES_W  = 32;
    localparam int IDX_W      = 4;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        START,
        WAIT,
        DRAIN,
        RELEASE
    } state_e;

    function automatic int elem_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/mm3x3_stream_ctrl_if.sv
// mm3x3_stream_ctrl_if: valid/ready element stream of width W.
//   valid  producer has data
//   ready  consumer accepts (transfer when valid && ready)
//   data   element
// Modports: master (producer side), slave (consumer side).
interface mm3x3_stream_ctrl_if #(
    parameter int W = 16
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mm3x3_stream_ctrl.sv
// mm3x3_stream_ctrl: initiator for a 3x3 matrix multiplier.
// Loads A then B (row-major, 9 elements each) from the input stream, drives the
// multiplier's flat operand buses, runs the level start / held done handshake,
// captures C and streams it back row-major with out_last on c22.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_s  (slave)     DATA_W element stream in (a00..a22, b00..b22)
//   out_m (master)    RES_W result stream out (c00..c22)
//   out_last          high with c22
//   busy              transaction in progress
//   err               WAIT watchdog expiry (sticky until reset or next input accept)
//   mm_a_flat/b_flat  operands, element i at [i*DATA_W +: DATA_W]
//   mm_start          level start to the multiplier
//   mm_c_flat         result, element i at [i*RES_W +: RES_W]
//   mm_done           multiplier done, held until start drops
// Build option: define MM_TIMEOUT_EN to enable the WAIT watchdog
// (TIMEOUT_CYCLES); otherwise err is tied 0 and WAIT blocks indefinitely.
module mm3x3_stream_ctrl
    import mm3x3_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int RES_W          = DEF_RES_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mm3x3_stream_ctrl_if.slave         in_s,
    mm3x3_stream_ctrl_if.master        out_m,
    output logic                       out_last,
    output logic                       busy,
    output logic                       err,
    output logic [NUM_ELEMS*DATA_W-1:0] mm_a_flat,
    output logic [NUM_ELEMS*DATA_W-1:0] mm_b_flat,
    output logic                       mm_start,
    input  logic [NUM_ELEMS*RES_W-1:0]  mm_c_flat,
    input  logic                       mm_done
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ELEMS - 1);

    // The watchdog compare needs at least a 1-bit counter.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2");
    end

    state_e                               state_q, state_d;
    logic [IDX_W-1:0]                     cnt_q, cnt_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic [NUM_ELEMS-1:0][DATA_W-1:0]     a_q, a_d;
    logic [NUM_ELEMS-1:0][DATA_W-1:0]     b_q, b_d;
    logic [NUM_ELEMS-1:0][RES_W-1:0]      res_q, res_d;
    logic [NUM_ELEMS-1:0][RES_W-1:0]      c_vec;
    logic                                 mm_start_q, mm_start_d;
    logic                                 in_rdy;
    logic                                 in_fire;
    logic                                 out_fire;

`ifdef MM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
`endif

    // Flat bus pack/unpack.
    for (genvar g = 0; g < NUM_ELEMS; g++) begin : g_flat
        assign mm_a_flat[elem_lsb(g, DATA_W) +: DATA_W] = a_q[g];
        assign mm_b_flat[elem_lsb(g, DATA_W) +: DATA_W] = b_q[g];
        assign c_vec[g] = mm_c_flat[elem_lsb(g, RES_W) +: RES_W];
    end

    // in_ready is gated by rst_n so every output reads 0 while reset is held.
    assign in_rdy     = rst_n && ((state_q == LOAD_A) || (state_q == LOAD_B));
    assign in_s.ready = in_rdy;
    assign in_fire    = in_s.valid && in_rdy;

    assign out_m.valid = (state_q == DRAIN);
    assign out_m.data  = res_q[idx_q];
    assign out_last    = (state_q == DRAIN) && (idx_q == LAST);
    assign out_fire    = out_m.valid && out_m.ready;

    assign mm_start = mm_start_q;
    assign busy     = (state_q != LOAD_A) || (cnt_q != '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        mm_start_d = mm_start_q;
`ifdef MM_TIMEOUT_EN
        tmo_d      = tmo_q;
        err_d      = err_q;
        if (in_fire) err_d = 1'b0;
`endif
        case (state_q)
            LOAD_A: begin
                if (in_fire) begin
                    a_d[cnt_q] = in_s.data;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (in_fire) begin
                    b_d[cnt_q] = in_s.data;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = START;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            START: begin
                mm_start_d = 1'b1;
                state_d    = WAIT;
`ifdef MM_TIMEOUT_EN
                tmo_d      = '0;
`endif
            end
            WAIT: begin
                // mm_start_q is always 1 here, so a done seen here belongs to this run.
                if (mm_done) begin
                    res_d      = c_vec;
                    mm_start_d = 1'b0;
                    idx_d      = '0;
                    state_d    = DRAIN;
                end
`ifdef MM_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    mm_start_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = RELEASE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            DRAIN: begin
                if (out_fire) begin
                    if (idx_q == LAST) state_d = RELEASE;
                    else               idx_d   = idx_q + 1'b1;
                end
            end
            RELEASE: begin
                // Let the multiplier drop done before a new run can start.
                if (!mm_done) state_d = LOAD_A;
            end
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD_A;
            cnt_q      <= '0;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            mm_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            mm_start_q <= mm_start_d;
        end
    end

`ifdef MM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mm3x3_stream_ctrl.sv
// Bench for mm3x3_stream_ctrl: behavioural 3x3 multiplier on the flat buses,
// reference results computed from the stimulus matrices, randomized gaps,
// output back-pressure and multiplier latency.
module tb_mm3x3_stream_ctrl;
    import mm3x3_pkg::*;

    localparam int DW  = 16;
    localparam int RW  = 32;
    localparam int TMO = 16;

    typedef logic [DW-1:0] mat_t [9];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mm3x3_stream_ctrl_if #(.W(DW)) in_if ();
    mm3x3_stream_ctrl_if #(.W(RW)) out_if ();

    logic            out_last, busy, err, mm_start, mm_done;
    logic            mm_done_raw = 1'b0;
    logic            kill_done = 1'b0;
    logic [9*DW-1:0] mm_a_flat, mm_b_flat;
    logic [9*RW-1:0] mm_c_flat = '0;
    int              mm_lat = 1;
    int              lat_cnt = 0;

    assign mm_done = mm_done_raw & ~kill_done;

    mm3x3_stream_ctrl #(.DATA_W(DW), .RES_W(RW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_s      (in_if),
        .out_m     (out_if),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err),
        .mm_a_flat (mm_a_flat),
        .mm_b_flat (mm_b_flat),
        .mm_start  (mm_start),
        .mm_c_flat (mm_c_flat),
        .mm_done   (mm_done)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Behavioural multiplier: latches operands off the flat buses after mm_lat
    // cycles of start, holds done until start drops. Results keep the low 32 bits.
    function automatic logic [9*RW-1:0] mul_flat(input logic [9*DW-1:0] a, input logic [9*DW-1:0] b);
        logic [63:0]     s;
        logic [9*RW-1:0] c;
        c = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                s = '0;
                for (int k = 0; k < 3; k++)
                    s += 64'(a[(i*3+k)*DW +: DW]) * 64'(b[(k*3+j)*DW +: DW]);
                c[(i*3+j)*RW +: RW] = s[RW-1:0];
            end
        return c;
    endfunction

    always @(posedge clk) begin
        if (!mm_start) begin
            mm_done_raw <= 1'b0;
            lat_cnt     <= 0;
        end else if (!mm_done_raw) begin
            if (lat_cnt >= mm_lat) begin
                mm_c_flat   <= mul_flat(mm_a_flat, mm_b_flat);
                mm_done_raw <= 1'b1;
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end
    end

    // Protocol monitor: start is low while draining, first result one cycle after done is sampled.
    logic prev_done_hit = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_if.valid) chk("start_low_in_drain", mm_start, 1'b0);
            if (prev_done_hit) chk("first_valid_latency", out_if.valid, 1'b1);
        end
        prev_done_hit <= rst_n && mm_start && mm_done;
    end

    // Reference: plain matrix product, low RW bits kept.
    function automatic void ref_mul(input mat_t a, input mat_t b, output logic [RW-1:0] c [9]);
        longint unsigned s;
        for (int r = 0; r < 3; r++)
            for (int col = 0; col < 3; col++) begin
                s = 0;
                for (int k = 0; k < 3; k++)
                    s += longint'(a[r*3+k]) * longint'(b[k*3+col]);
                c[r*3+col] = s[RW-1:0];
            end
    endfunction

    // Called at a negedge; returns at the negedge after the element is accepted.
    task automatic push(input logic [DW-1:0] d);
        int n;
        n = 0;
        repeat ($urandom_range(0, 2)) begin
            in_if.valid = 1'b0;
            @(negedge clk);
        end
        in_if.valid = 1'b1;
        in_if.data  = d;
        while (!in_if.ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("push_timeout", 1'b0, 1'b1);
        @(negedge clk);
        in_if.valid = 1'b0;
    endtask

    // rmode: 0 always ready, 1 toggling, 2 random. abort_at: beat index to reset at (-1 none).
    task automatic run_txn(input string nm, input mat_t a, input mat_t b, input int rmode,
                           input int abort_at, input int pre_pushed);
        logic [RW-1:0] exp [9];
        logic [RW-1:0] hold_val;
        logic          hold_pend;
        int            k, n;
        ref_mul(a, b, exp);
        mm_lat = $urandom_range(1, 6);
        for (int i = pre_pushed; i < 9; i++) push(a[i]);
        for (int i = 0; i < 9; i++) push(b[i]);
        chk({nm, "_busy_loaded"}, busy, 1'b1);
        @(negedge clk);
        chk({nm, "_start_high"}, mm_start, 1'b1);
        k = 0;
        hold_pend = 1'b0;
        hold_val = '0;
        for (int cyc = 0; cyc < 400 && k < 9; cyc++) begin
            case (rmode)
                0:       out_if.ready = 1'b1;
                1:       out_if.ready = (cyc % 2) == 0;
                default: out_if.ready = 1'($urandom_range(0, 1));
            endcase
            if (hold_pend) begin
                chk({nm, "_hold_valid"}, out_if.valid, 1'b1);
                chk({nm, "_hold_data"}, out_if.data, hold_val);
            end
            if (k == abort_at && out_if.valid) begin
                out_if.ready = 1'b0;
                rst_n = 1'b0;
                #1;
                chk({nm, "_rst_valid"}, out_if.valid, 1'b0);
                chk({nm, "_rst_start"}, mm_start, 1'b0);
                chk({nm, "_rst_busy"}, busy, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            hold_pend = out_if.valid && !out_if.ready;
            hold_val  = out_if.data;
            if (out_if.valid && out_if.ready) begin
                chk({nm, "_data"}, out_if.data, exp[k]);
                chk({nm, "_last"}, out_last, k == 8);
                k++;
            end
            @(negedge clk);
        end
        chk({nm, "_beats"}, k, 9);
        out_if.ready = 1'b0;
        n = 0;
        while (busy && n < 30) begin
            chk({nm, "_no_extra"}, out_if.valid, 1'b0);
            @(negedge clk);
            n++;
        end
        chk({nm, "_idle_busy"}, busy, 1'b0);
        chk({nm, "_idle_valid"}, out_if.valid, 1'b0);
    endtask

    initial begin
        mat_t a, b;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_if.ready, 1'b0);
        chk("rst_out_valid", out_if.valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_mm_start", mm_start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_a_flat", 64'(mm_a_flat[63:0]), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_if.ready, 1'b1);

        for (int i = 0; i < 9; i++) begin
            a[i] = (i % 4 == 0) ? DW'(1) : DW'(0);
            b[i] = DW'(i + 1);
        end
        run_txn("ident", a, b, 0, -1, 0);

        for (int i = 0; i < 9; i++) begin a[i] = DW'(2); b[i] = DW'(3); end
        run_txn("twos", a, b, 2, -1, 0);

        for (int i = 0; i < 9; i++) begin a[i] = '1; b[i] = '1; end
        run_txn("ones", a, b, 1, -1, 0);

        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 9; i++) begin
                a[i] = DW'($urandom);
                b[i] = DW'($urandom);
            end
            run_txn("rand", a, b, 2, -1, 0);
        end

        for (int i = 0; i < 9; i++) begin a[i] = DW'($urandom); b[i] = DW'($urandom); end
        run_txn("abort", a, b, 0, 4, 0);
        chk("abort_idle_ready", in_if.ready, 1'b1);
        for (int i = 0; i < 9; i++) begin a[i] = DW'($urandom); b[i] = DW'($urandom); end
        run_txn("after_abort", a, b, 1, -1, 0);

`ifdef MM_TIMEOUT_EN
        begin
            int cnt;
            kill_done = 1'b1;
            for (int i = 0; i < 9; i++) begin a[i] = DW'($urandom); b[i] = DW'($urandom); end
            for (int i = 0; i < 9; i++) push(a[i]);
            for (int i = 0; i < 9; i++) push(b[i]);
            @(negedge clk);
            chk("tmo_start_high", mm_start, 1'b1);
            cnt = 0;
            while (!err && cnt < 100) begin
                chk("tmo_no_valid", out_if.valid, 1'b0);
                @(negedge clk);
                cnt++;
            end
            chk("tmo_cycles", cnt, TMO);
            chk("tmo_start_low", mm_start, 1'b0);
            chk("tmo_err", err, 1'b1);
            repeat (3) @(negedge clk);
            kill_done = 1'b0;
            chk("tmo_err_sticky", err, 1'b1);
            chk("tmo_no_valid_after", out_if.valid, 1'b0);
            for (int i = 0; i < 9; i++) begin a[i] = DW'($urandom); b[i] = DW'($urandom); end
            push(a[0]);
            chk("tmo_err_cleared", err, 1'b0);
            run_txn("after_tmo", a, b, 2, -1, 1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
